// File: rtl/result_drain_pkg.sv
// Shared FSM encoding, buffer sizing and credit helper for result_drain.
// Optional feature macro used by the block: RESULT_DRAIN_TRANSPOSE_EN (column-major readout).
package result_drain_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int BUF_DEPTH = 2;
  localparam int CRED_W    = $clog2(BUF_DEPTH + 1);

  typedef logic [CRED_W-1:0] cred_t;
  typedef logic [CRED_W:0]   occ_t;

  // Words that will occupy the buffer after this edge: stored, landing now and
  // already requested, minus the one leaving. A new read fits only below depth.
  function automatic logic credit_ok(input cred_t stored,
                                     input logic  arriving,
                                     input logic  issuing,
                                     input logic  popping);
    occ_t occ;
    occ = occ_t'(stored) + occ_t'(arriving) + occ_t'(issuing) - occ_t'(popping);
    return occ < occ_t'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Output word stream of result_drain: valid/ready handshake with a last-word marker.
interface result_drain_if #(
  parameter int DATA_W = 16
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input  m_ready);
  modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);
endinterface

// File: rtl/drain_skid_buf.sv
// Two-entry fall-through FIFO for read responses; an incoming word is visible on the
// output in the cycle it arrives when the FIFO is empty.
module drain_skid_buf
  import result_drain_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output cred_t        count
);

  logic [W-1:0] mem_q [BUF_DEPTH];
  // Single-bit pointers: the depth is fixed at two.
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  cred_t        count_q, count_d;
  logic         store;
  logic         take;

  always_comb begin
    store    = push && !(pop && (count_q == '0));
    take     = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q ^ store;
    rd_ptr_d = rd_ptr_q ^ take;
    count_d  = count_q + cred_t'(store) - cred_t'(take);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; count_q gates every read of it, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign out_valid = (count_q != '0) || push;
  assign out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : (push ? push_data : '0);
  assign count     = count_q;

endmodule

// File: rtl/result_drain.sv
// Streams the ROWS x COLS result matrix out of the result memory onto a valid/ready stream.
// Define RESULT_DRAIN_TRANSPOSE_EN for column-major output order instead of row-major.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int BASE_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  result_drain_if.master    m,
  output logic              busy,
  output logic              drain_done
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = $clog2(N + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam cnt_t LAST_IDX = cnt_t'(N - 1);
  localparam cnt_t N_CNT    = cnt_t'(N);

  logic [1:0] state_q, state_d;
  cnt_t       iss_cnt_q, iss_cnt_d;
  logic       rd_en_q, rd_en_d;
  addr_t      rd_addr_q, rd_addr_d;
  logic       rd_last_q, rd_last_d;
  logic       rsp_vld_q, rsp_last_q;

  logic              can_issue;
  logic              issue;
  logic              pop;
  addr_t             elem_addr;
  logic              buf_valid;
  logic [DATA_W:0]   buf_word;
  cred_t             buf_count;

`ifdef RESULT_DRAIN_TRANSPOSE_EN
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef logic [RW-1:0] row_t;
  typedef logic [CW-1:0] col_t;

  localparam row_t ROW_LAST = row_t'(ROWS - 1);

  row_t row_q, row_d;
  col_t col_q, col_d;
`endif

  assign pop = buf_valid && m.m_ready;

`ifdef RESULT_DRAIN_TRANSPOSE_EN
  assign elem_addr = addr_t'(BASE_ADDR) + addr_t'(row_q) * addr_t'(COLS) + addr_t'(col_q);
`else
  assign elem_addr = addr_t'(BASE_ADDR) + addr_t'(iss_cnt_q);
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_last_d = 1'b0;
    can_issue = 1'b0;
`ifdef RESULT_DRAIN_TRANSPOSE_EN
    row_d     = row_q;
    col_d     = col_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_READ;
          can_issue = 1'b1;
        end
      end
      ST_READ:  can_issue = 1'b1;
      ST_FLUSH: begin
        if (pop && buf_word[DATA_W]) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    issue = can_issue && (iss_cnt_q != N_CNT) &&
            credit_ok(buf_count, rsp_vld_q, rd_en_q, pop);

    if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = elem_addr;
      rd_last_d = (iss_cnt_q == LAST_IDX);
      iss_cnt_d = iss_cnt_q + cnt_t'(1);
      if (iss_cnt_q == LAST_IDX) begin
        state_d = ST_FLUSH;
      end
`ifdef RESULT_DRAIN_TRANSPOSE_EN
      if (row_q == ROW_LAST) begin
        row_d = '0;
        col_d = col_q + col_t'(1);
      end else begin
        row_d = row_q + row_t'(1);
      end
`endif
    end

    // Counters return to zero so the next start always begins at element (0,0).
    if (state_q == ST_DONE) begin
      iss_cnt_d = '0;
`ifdef RESULT_DRAIN_TRANSPOSE_EN
      row_d     = '0;
      col_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      iss_cnt_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_last_q <= 1'b0;
`ifdef RESULT_DRAIN_TRANSPOSE_EN
      row_q      <= '0;
      col_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      iss_cnt_q  <= iss_cnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_last_q  <= rd_last_d;
      rsp_vld_q  <= rd_en_q;
      rsp_last_q <= rd_last_q;
`ifdef RESULT_DRAIN_TRANSPOSE_EN
      row_q      <= row_d;
      col_q      <= col_d;
`endif
    end
  end

  // Memory data lands one cycle after the strobe and is pushed unconditionally;
  // the credit check guarantees room for it.
  drain_skid_buf #(
    .W(DATA_W + 1)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_vld_q),
    .push_data ({rsp_last_q, rd_data}),
    .pop       (pop),
    .out_valid (buf_valid),
    .out_data  (buf_word),
    .count     (buf_count)
  );

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign m.m_valid  = buf_valid;
  assign m.m_data   = buf_word[DATA_W-1:0];
  assign m.m_last   = buf_valid && buf_word[DATA_W];
  assign busy       = (state_q == ST_READ) || (state_q == ST_FLUSH);
  assign drain_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: expected words queued at start, monitor compares handshakes.
module tb_result_drain;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int BASE_ADDR = 1;
  localparam int N         = ROWS * COLS;

`ifdef RESULT_DRAIN_TRANSPOSE_EN
  localparam logic [DATA_W-1:0] EXP_WORDS [N] = '{
    16'hA001, 16'hA005, 16'hA009, 16'hA00D,
    16'hA002, 16'hA006, 16'hA00A, 16'hA00E,
    16'hA003, 16'hA007, 16'hA00B, 16'hA00F,
    16'hA004, 16'hA008, 16'hA00C, 16'hA010};
`else
  localparam logic [DATA_W-1:0] EXP_WORDS [N] = '{
    16'hA001, 16'hA002, 16'hA003, 16'hA004,
    16'hA005, 16'hA006, 16'hA007, 16'hA008,
    16'hA009, 16'hA00A, 16'hA00B, 16'hA00C,
    16'hA00D, 16'hA00E, 16'hA00F, 16'hA010};
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              busy;
  logic              drain_done;

  int n_checks   = 0;
  int n_pass     = 0;
  int hs_count   = 0;
  int rd_count   = 0;
  int done_count = 0;

  logic [DATA_W:0] exp_q [$];

  result_drain_if #(.DATA_W(DATA_W)) m_if ();

  result_drain #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ROWS      (ROWS),
    .COLS      (COLS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m          (m_if),
    .busy       (busy),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  // Result memory: address a holds 16'hA000 + a, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 16'hA000 + 16'(rd_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every handshake against the scoreboard and checks stall stability.
  logic            stall_prev = 1'b0;
  logic [DATA_W:0] stall_word = '0;
  logic [DATA_W:0] exp_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (rd_en) rd_count++;
      if (drain_done) done_count++;
      if (stall_prev)
        check("stall_hold", 32'({m_if.m_valid, m_if.m_last, m_if.m_data}), 32'({1'b1, stall_word}));
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_word: got %0h while no word was expected (t=%0t)", m_if.m_data, $time);
        end else begin
          exp_word = exp_q.pop_front();
          check("word", 32'({m_if.m_last, m_if.m_data}), 32'(exp_word));
        end
        hs_count++;
      end
      stall_prev = m_if.m_valid && !m_if.m_ready;
      stall_word = {m_if.m_last, m_if.m_data};
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_rd_en"},      32'(rd_en),        0);
    check({tag, "_rd_addr"},    32'(rd_addr),      0);
    check({tag, "_m_valid"},    32'(m_if.m_valid), 0);
    check({tag, "_m_data"},     32'(m_if.m_data),  0);
    check({tag, "_m_last"},     32'(m_if.m_last),  0);
    check({tag, "_busy"},       32'(busy),         0);
    check({tag, "_drain_done"}, 32'(drain_done),   0);
  endtask

  task automatic load_expected();
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), EXP_WORDS[i]});
  endtask

  // Leaves the caller just after the edge that sampled start (cycle k+1).
  task automatic issue_start();
    @(posedge clk); #1 start = 1'b1;
    load_expected();
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (drain_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0, d0, r0, vcnt;
    bit seen;
    m_if.m_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full-speed drain: exact start latency and 16 back-to-back words.
    #1 m_if.m_ready = 1'b1;
    h0 = hs_count;
    issue_start();
    @(negedge clk);
    check("t1_rd_en_k1",   32'(rd_en),        1);
    check("t1_rd_addr_k1", 32'(rd_addr),      BASE_ADDR);
    check("t1_valid_k1",   32'(m_if.m_valid), 0);
    check("t1_busy",       32'(busy),         1);
    @(negedge clk);
    check("t1_valid_k2", 32'(m_if.m_valid), 1);
    vcnt = int'(m_if.m_valid);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      vcnt += int'(m_if.m_valid);
    end
    check("t1_consec_valid", vcnt, N);
    @(negedge clk);
    check("t1_drain_done", 32'(drain_done), 1);
    check("t1_busy_end",   32'(busy),       0);
    @(negedge clk);
    check("t1_done_pulse", 32'(drain_done), 0);
    check("t1_words",      hs_count - h0,   N);
    check("t1_sb_empty",   exp_q.size(),    0);

    // Ready toggling every cycle.
    m_if.m_ready = 1'b0;
    h0 = hs_count;
    d0 = done_count;
    issue_start();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (drain_done) seen = 1'b1;
      @(posedge clk); #1 m_if.m_ready = ~m_if.m_ready;
    end
    check("t2_done_seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
    check("t2_words",    hs_count - h0,   N);
    check("t2_one_done", done_count - d0, 1);
    check("t2_sb_empty", exp_q.size(),    0);

    // Ten-cycle stall right after the first valid word.
    @(posedge clk); #1 m_if.m_ready = 1'b0;
    h0 = hs_count;
    r0 = rd_count;
    issue_start();
    @(negedge clk);
    @(negedge clk);
    check("t3_first_valid", 32'(m_if.m_valid), 1);
    repeat (9) @(negedge clk);
    check("t3_reads_stalled", rd_count - r0, 2);
    check("t3_rd_en_low",     32'(rd_en),    0);
    check("t3_no_words",      hs_count - h0, 0);
    @(posedge clk); #1 m_if.m_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      vcnt += int'(m_if.m_valid);
    end
    check("t3_consec_valid", vcnt, N);
    @(negedge clk);
    check("t3_drain_done", 32'(drain_done), 1);
    check("t3_words",      hs_count - h0,   N);

    // Second start mid-drain must be ignored.
    repeat (2) @(posedge clk);
    h0 = hs_count;
    d0 = done_count;
    issue_start();
    repeat (5) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t4", 100);
    repeat (6) @(negedge clk);
    check("t4_one_done", done_count - d0, 1);
    check("t4_words",    hs_count - h0,   N);
    check("t4_idle",     32'(busy),       0);

    // Reset after the fifth word aborts the drain; a new start drains everything again.
    h0 = hs_count;
    d0 = done_count;
    issue_start();
    for (int i = 0; i < 50 && (hs_count - h0) < 5; i++) @(negedge clk);
    check("t5_five_words", hs_count - h0, 5);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    #1 reset_checks("t5_abort");
    repeat (3) @(negedge clk);
    reset_checks("t5_held");
    check("t5_no_done", done_count - d0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    h0 = hs_count;
    issue_start();
    wait_done("t5_redo", 100);
    check("t5_redo_words", hs_count - h0, N);
    check("t5_sb_empty",   exp_q.size(),  0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Streams the ROWS×COLS result matrix out of the systolic array's C result memory once a computation finishes. It generates read addresses and absorbs the memory's fixed one-cycle read latency, then presents each word on a valid/ready stream with a last-word marker, so software-side or downstream logic needs no hand-timed readout. It sits between the array controller's result memory read port and the output stream interface.

## Interface
- DATA_W, 16, result word width
- ADDR_W, 5, result memory address width
- ROWS, 4, result matrix rows
- COLS, 4, result matrix columns
- BASE_ADDR, 1, memory address of element (0,0); element (r,c) lives at BASE_ADDR + r*COLS + c
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begin a drain (typically the array's done rising edge)
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  DATA_W  memory read data, valid the cycle after rd_en
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  DATA_W  output word
- m_last  out  1  marks final word of matrix, qualified by m_valid
- busy  out  1  drain in progress
- drain_done  out  1  one-cycle pulse after final handshake

## Operation
- FSM states: IDLE, READ, FLUSH, DONE.
- IDLE: start=1 -> READ; element counters r=c=0; busy=1.
- READ: issue rd_en when credits allow (occupancy + outstanding read < 2); advance element counter per issued read; after issuing element ROWS*COLS-1 -> FLUSH.
- FLUSH: wait for buffer empty with final word handshaken -> DONE.
- DONE: drain_done=1 for one cycle, busy=0 -> IDLE.
- Read data captured unconditionally into a 2-entry buffer the cycle after rd_en; credit scheme guarantees no overflow.
- Output order: row-major (c fastest) by default.
- m_last=1 exactly on element ROWS*COLS-1 in output order.
- start while busy: ignored, no restart.
- Handshake: word transfers when m_valid && m_ready; m_valid and m_data held stable while m_valid && !m_ready.
- rd_addr width: BASE_ADDR + ROWS*COLS-1 must fit ADDR_W; address arithmetic computed at ADDR_W, no wrap expected.
- rst_n low mid-drain: immediate abort, buffer emptied, state IDLE, no drain_done.

## Timing
- Reset values: rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, drain_done=0.
- start sampled at edge k -> rd_en=1 with rd_addr=BASE_ADDR in cycle k+1; m_valid=1 in cycle k+2.
- m_ready held high: one word per cycle, ROWS*COLS consecutive valid cycles, drain_done in cycle after last handshake.
- m_ready low: at most two reads outstanding/buffered; reads resume cycle after a handshake frees a slot.
- Full buffer plus m_ready rising: no bubble; throughput returns to 1 word/cycle.

## Configuration
- RESULT_DRAIN_TRANSPOSE_EN defined: output order column-major (r fastest), address BASE_ADDR + r*COLS + c; m_last on element (ROWS-1,COLS-1).
- Undefined: row-major only; transpose counter logic absent.

## Structure
- Package result_drain_pkg: FSM state encoding, buffer depth constant (2), credit width.
- Sub-module drain_skid_buf: 2-entry FIFO with push, pop, count, DATA_W+1 wide (data plus last flag).

## Test plan
- Reset, memory preloaded address a holds 16'hA000+a, start, m_ready=1 -> 16 words 16'hA001..16'hA010 in 16 consecutive cycles, m_last on 16'hA010, drain_done next cycle.
- m_ready toggling 1/0 each cycle -> same 16 words in order, no duplicates/drops, m_data stable while stalled.
- m_ready low 10 cycles after first valid -> exactly 2 reads issued then rd_en held 0; release -> remaining 14 words flow at 1/cycle.
- start pulsed again mid-drain -> ignored; one drain_done only.
- rst_n asserted after 5th word -> all outputs to reset values same cycle; new start -> full 16-word drain from 16'hA001.
- RESULT_DRAIN_TRANSPOSE_EN, ROWS=COLS=4 -> order 16'hA001, 16'hA005, 16'hA009, 16'hA00D, 16'hA002, …, 16'hA010 with m_last.
